// File: rtl/rr_rx_arbiter_if.sv
// rr_rx_arbiter_if -- bundle between five receive ports, the arbiter and the
// downstream FIFO.
//
// Signals:
//   full            downstream FIFO full (no transfer while high)
//   x_valid/x_item  port x has a head item pending, and that item
//   x_read          pop strobe back to port x
//   write/item_out  push strobe and data towards the FIFO
//   owner           current priority pointer (0=N,1=S,2=E,3=W,4=L)
//   dbg_cnt         burst counter of the current owner (observation only)
//
// Handshake: an item moves from port x to the FIFO in exactly the cycle where
// x_read and write are both high. x_valid acts as the source's valid and
// !full as the sink's ready. Both are sampled combinationally, so a read is
// raised in the same cycle that x_valid is high and full is low.
// A port must hold x_item stable while x_valid is high and x_read is low.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 32
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

interface rr_rx_arbiter_if #(
  parameter int ITEM_W = `PAYLOAD_SIZE + `ADDR_SZ
);
  logic              full;
  logic              n_valid, s_valid, e_valid, w_valid, l_valid;
  logic [ITEM_W-1:0] n_item, s_item, e_item, w_item, l_item;
  logic              n_read, s_read, e_read, w_read, l_read;
  logic              write;
  logic [ITEM_W-1:0] item_out;
  logic [2:0]        owner;
  logic [3:0]        dbg_cnt;

  // Arbiter side.
  modport slave (
    input  full,
    input  n_valid, s_valid, e_valid, w_valid, l_valid,
    input  n_item, s_item, e_item, w_item, l_item,
    output n_read, s_read, e_read, w_read, l_read,
    output write, item_out, owner, dbg_cnt
  );

  // Environment side (ports plus FIFO).
  modport master (
    output full,
    output n_valid, s_valid, e_valid, w_valid, l_valid,
    output n_item, s_item, e_item, w_item, l_item,
    input  n_read, s_read, e_read, w_read, l_read,
    input  write, item_out, owner, dbg_cnt
  );
endinterface

// File: rtl/rr_rx_arbiter.sv
// rr_rx_arbiter -- five-port (N,S,E,W,L) round-robin arbiter feeding one FIFO.
// A port may hold priority for up to QUANTUM consecutive grants before the
// pointer moves on to the next port in the cyclic order N,S,E,W,L.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (pointer to N, burst count to 0)
//   bus   rr_rx_arbiter_if.slave: valids/items/full in; reads, write,
//         item_out, owner (pointer) and dbg_cnt (burst count) out
//
// Selection is combinational: read/write follow valid and full in the same
// cycle. Only the pointer and the burst count are registered.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 32
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

module rr_rx_arbiter #(
  parameter int ITEM_W  = `PAYLOAD_SIZE + `ADDR_SZ,
  parameter int QUANTUM = 4
) (
  input logic            clk,
  input logic            rst,
  rr_rx_arbiter_if.slave bus
);

  logic [2:0]        r_ptr;
  logic [3:0]        r_cnt;

  logic [4:0]        w_valid;
  logic [ITEM_W-1:0] w_items [5];
  logic [2:0]        w_ptr_eff;
  logic [2:0]        w_sel;
  logic              w_any;
  logic              w_grant;
  logic [4:0]        w_read;
  logic [3:0]        w_base;
  logic [4:0]        w_base_inc;
  logic [2:0]        w_ptr_nxt;
  logic [3:0]        w_cnt_nxt;

  assign w_valid = {bus.l_valid, bus.w_valid, bus.e_valid, bus.s_valid, bus.n_valid};

  assign w_items[0] = bus.n_item;
  assign w_items[1] = bus.s_item;
  assign w_items[2] = bus.e_item;
  assign w_items[3] = bus.w_item;
  assign w_items[4] = bus.l_item;

  // An illegal pointer (5..7) behaves exactly like N.
  assign w_ptr_eff = (r_ptr > 3'd4) ? 3'd0 : r_ptr;
  assign w_any     = |w_valid;
  assign w_grant   = w_any & ~bus.full & ~rst;

  // First valid port scanning cyclically from the pointer.
  always_comb begin
    logic [3:0] v_idx;
    logic       v_found;
    w_sel   = w_ptr_eff;
    v_found = 1'b0;
    v_idx   = 4'd0;
    for (int k = 0; k < 5; k++) begin
      v_idx = {1'b0, w_ptr_eff} + 4'(k);
      if (v_idx > 4'd4) v_idx = v_idx - 4'd5;
      if (!v_found && w_valid[v_idx[2:0]]) begin
        v_found = 1'b1;
        w_sel   = v_idx[2:0];
      end
    end
  end

  // Burst accounting: a grant to the pointer's own port continues its burst;
  // a grant to any other port (owner idle or dropped) starts a fresh burst.
  always_comb begin
    w_base     = (w_sel == w_ptr_eff) ? r_cnt : 4'd0;
    w_base_inc = {1'b0, w_base} + 5'd1;
    if (w_base_inc == 5'(QUANTUM)) begin
      w_ptr_nxt = (w_sel == 3'd4) ? 3'd0 : w_sel + 3'd1;
      w_cnt_nxt = 4'd0;
    end else begin
      w_ptr_nxt = w_sel;
      w_cnt_nxt = w_base_inc[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 3'd0;
      r_cnt <= 4'd0;
    end else if (w_grant) begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign w_read = w_grant ? (5'b00001 << w_sel) : 5'b00000;

  assign bus.n_read   = w_read[0];
  assign bus.s_read   = w_read[1];
  assign bus.e_read   = w_read[2];
  assign bus.w_read   = w_read[3];
  assign bus.l_read   = w_read[4];
  assign bus.write    = w_grant;
  assign bus.item_out = w_any ? w_items[w_sel] : '0;
  assign bus.owner    = r_ptr;
  assign bus.dbg_cnt  = r_cnt;

endmodule
